// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: FSM states,
// instruction classes, opcodes, ALU operation codes and immediate formats.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_ILLEGAL = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_IALU   = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8,
        CLS_BAD    = 4'd9
    } instr_class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // funct7[5] selects SUB only for register-register ops; SRA for both forms
    function automatic logic [3:0] alu_op_from_funct(input logic [2:0] funct3,
                                                     input logic       funct7_b5,
                                                     input logic       is_reg);
        logic [3:0] op;
        case (funct3)
            3'd0:    op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            3'd7:    op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational decode of the latched instruction fields into an instruction
// class, ALU operation and immediate format.
module ctrl_decoder
    import riscv_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         funct7_b5,
    output instr_class_e cls,
    output logic [3:0]   alu_control,
    output logic [2:0]   imm_sel
);

    // Opcode classification with per-class ALU and immediate selection
    always_comb begin
        cls         = CLS_BAD;
        alu_control = ALU_ADD;
        imm_sel     = IMM_I;
        case (opcode)
            OP_R: begin
                cls         = CLS_R;
                alu_control = alu_op_from_funct(funct3, funct7_b5, 1'b1);
            end
            OP_IALU: begin
                cls         = CLS_IALU;
                alu_control = alu_op_from_funct(funct3, funct7_b5, 1'b0);
            end
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE: begin
                cls     = CLS_STORE;
                imm_sel = IMM_S;
            end
            OP_BRANCH: begin
                cls         = CLS_BRANCH;
                alu_control = ALU_SUB;
                imm_sel     = IMM_B;
            end
            OP_JAL: begin
                cls     = CLS_JAL;
                imm_sel = IMM_J;
            end
            OP_JALR:   cls = CLS_JALR;
            OP_LUI: begin
                cls     = CLS_LUI;
                imm_sel = IMM_U;
            end
            OP_AUIPC: begin
                cls     = CLS_AUIPC;
                imm_sel = IMM_U;
            end
            default:   cls = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and write-back
// sequencing with a latched instruction register and sticky illegal flag.
module control_fsm
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic [3:0]  alu_control,
    output logic [2:0]  imm_sel,
    output logic [2:0]  br_sel,
    output logic [2:0]  dm_sel,
    output logic [2:0]  store_sel,
    output logic        dm_req,
    output logic        dm_write,
    output logic        reg_write,
    output logic        wd_src,
    output logic        illegal,
    output logic [2:0]  state
);

    state_e       state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    logic         illegal_q, illegal_d;
    instr_class_e cls_s;
    logic [3:0]   alu_s;
    logic [2:0]   imm_s;
    logic         imem_req_s, ir_write_s, pc_write_s, pc_src_s;
    logic         dm_req_s, dm_write_s, reg_write_s, wd_src_s;
    logic         unused_ir_bits_s;

    ctrl_decoder u_dec (
        .opcode      (ir_q[6:0]),
        .funct3      (ir_q[14:12]),
        .funct7_b5   (ir_q[30]),
        .cls         (cls_s),
        .alu_control (alu_s),
        .imm_sel     (imm_s)
    );

    // Register fields and immediates are consumed by the datapath, not here
    assign unused_ir_bits_s = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

    // Next-state, instruction latch and per-state control strobes
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        imem_req_s  = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        pc_src_s    = 1'b0;
        dm_req_s    = 1'b0;
        dm_write_s  = 1'b0;
        reg_write_s = 1'b0;
        wd_src_s    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready) begin
                    ir_write_s = 1'b1;
                    ir_d       = instr;
                    state_d    = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (cls_s == CLS_BAD) begin
                    state_d = ST_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_s)
                    CLS_R, CLS_IALU, CLS_LUI, CLS_AUIPC: state_d = ST_WB;
                    CLS_LOAD, CLS_STORE:                 state_d = ST_MEM;
                    CLS_BRANCH: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = br_taken;
                        state_d    = ST_FETCH;
                    end
                    CLS_JAL, CLS_JALR: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = 1'b1;
                        state_d    = ST_WB;
                    end
                    default: state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEM: begin
                dm_req_s   = 1'b1;
                dm_write_s = (cls_s == CLS_STORE);
                if (dmem_ready) begin
                    if (cls_s == CLS_STORE) begin
                        pc_write_s = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                reg_write_s = 1'b1;
                wd_src_s    = (cls_s == CLS_LOAD);
                // Jumps already redirected the PC in EXEC
                if ((cls_s == CLS_JAL) || (cls_s == CLS_JALR)) begin
                    pc_write_s = 1'b0;
                end else begin
                    pc_write_s = 1'b1;
                end
                state_d = ST_FETCH;
            end
            ST_ILLEGAL: state_d = ST_ILLEGAL;
            default:    state_d = ST_FETCH;
        endcase
        illegal_d = illegal_q | (state_d == ST_ILLEGAL);
    end

    // State, instruction register and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            ir_q      <= NOP_INSTR;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Enables are masked by rst so an abandoned access drops without a clock
    assign imem_req  = imem_req_s  & ~rst;
    assign ir_write  = ir_write_s  & ~rst;
    assign pc_write  = pc_write_s  & ~rst;
    assign pc_src    = pc_src_s    & ~rst;
    assign dm_req    = dm_req_s    & ~rst;
    assign dm_write  = dm_write_s  & ~rst;
    assign reg_write = reg_write_s & ~rst;
    assign wd_src    = wd_src_s    & ~rst;

    assign alu_control = alu_s;
    assign imm_sel     = imm_s;
    assign br_sel      = ir_q[14:12];
    assign dm_sel      = ir_q[14:12];
    assign store_sel   = ir_q[14:12];
    assign illegal     = illegal_q;
    assign state       = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks instruction classes through the FSM
// and checks strobes, selects and reset behaviour against hand-derived values.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        imem_ready, dmem_ready, br_taken;
    logic        imem_req, ir_write, pc_write, pc_src;
    logic [3:0]  alu_control;
    logic [2:0]  imm_sel, br_sel, dm_sel, store_sel;
    logic        dm_req, dm_write, reg_write, wd_src, illegal;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    logic [31:0] alu_words [8];
    logic [3:0]  alu_exp   [8];

    always #5 clk = ~clk;

    control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .br_taken    (br_taken),
        .imem_req    (imem_req),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .imm_sel     (imm_sel),
        .br_sel      (br_sel),
        .dm_sel      (dm_sel),
        .store_sel   (store_sel),
        .dm_req      (dm_req),
        .dm_write    (dm_write),
        .reg_write   (reg_write),
        .wd_src      (wd_src),
        .illegal     (illegal),
        .state       (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while in FETCH: present a word, check the fetch, land in DECODE
    task automatic fetch_decode(input logic [31:0] word);
        instr      = word;
        imem_ready = 1'b1;
        #1;
        chk("fetch.state", {29'd0, state}, 32'd0);
        chk("fetch.imem_req", {31'd0, imem_req}, 32'd1);
        chk("fetch.ir_write", {31'd0, ir_write}, 32'd1);
        tick();
        imem_ready = 1'b0;
        #1;
        chk("decode.state", {29'd0, state}, 32'd1);
        chk("decode.imem_req", {31'd0, imem_req}, 32'd0);
        chk("decode.ir_write", {31'd0, ir_write}, 32'd0);
    endtask

    initial begin
        alu_words[0] = 32'h402081B3; alu_exp[0] = 4'd1;  // SUB
        alu_words[1] = 32'h4020D1B3; alu_exp[1] = 4'd7;  // SRA
        alu_words[2] = 32'h4020D193; alu_exp[2] = 4'd7;  // SRAI
        alu_words[3] = 32'h40008193; alu_exp[3] = 4'd0;  // ADDI with bit30 set stays ADD
        alu_words[4] = 32'h0020D1B3; alu_exp[4] = 4'd6;  // SRL
        alu_words[5] = 32'h0020F1B3; alu_exp[5] = 4'd9;  // AND
        alu_words[6] = 32'h0020B1B3; alu_exp[6] = 4'd4;  // SLTU
        alu_words[7] = 32'h000011B7; alu_exp[7] = 4'd0;  // LUI

        rst = 1'b1; instr = 32'd0; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
        #2;
        chk("rst.state", {29'd0, state}, 32'd0);
        chk("rst.imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst.enables", {26'd0, ir_write, pc_write, dm_req, dm_write, reg_write, wd_src}, 32'd0);
        chk("rst.illegal", {31'd0, illegal}, 32'd0);
        chk("rst.nop_alu", {28'd0, alu_control}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst.imem_req", {31'd0, imem_req}, 32'd1);

        // ADD: FETCH, DECODE, EXEC, WB
        fetch_decode(32'h002081B3);
        chk("add.alu", {28'd0, alu_control}, 32'd0);
        tick();
        chk("add.exec_state", {29'd0, state}, 32'd2);
        chk("add.exec_pc_write", {31'd0, pc_write}, 32'd0);
        tick();
        chk("add.wb_state", {29'd0, state}, 32'd4);
        chk("add.wb_reg_write", {31'd0, reg_write}, 32'd1);
        chk("add.wb_wd_src", {31'd0, wd_src}, 32'd0);
        chk("add.wb_pc", {30'd0, pc_write, pc_src}, 32'd2);
        chk("add.wb_alu", {28'd0, alu_control}, 32'd0);
        tick();
        chk("add.back_fetch", {29'd0, state}, 32'd0);

        // ALU decode table
        for (int i = 0; i < 8; i++) begin
            fetch_decode(alu_words[i]);
            chk($sformatf("alu%0d.op", i), {28'd0, alu_control}, {28'd0, alu_exp[i]});
            tick();
            tick();
            chk($sformatf("alu%0d.wb", i), {29'd0, state}, 32'd4);
            tick();
        end

        // LW with three stalled MEM cycles
        fetch_decode(32'h0000A283);
        tick();
        chk("lw.exec_state", {29'd0, state}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("lw.mem%0d_state", i), {29'd0, state}, 32'd3);
            chk($sformatf("lw.mem%0d_dm", i), {30'd0, dm_req, dm_write}, 32'd2);
            chk($sformatf("lw.mem%0d_pc_write", i), {31'd0, pc_write}, 32'd0);
        end
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("lw.mem3_state", {29'd0, state}, 32'd3);
        chk("lw.mem3_dm", {30'd0, dm_req, dm_write}, 32'd2);
        chk("lw.dm_sel", {29'd0, dm_sel}, 32'd2);
        chk("lw.mem3_pc_write", {31'd0, pc_write}, 32'd0);
        tick();
        dmem_ready = 1'b0;
        #1;
        chk("lw.wb_state", {29'd0, state}, 32'd4);
        chk("lw.wb_strobes", {29'd0, reg_write, wd_src, pc_write}, 32'd7);
        tick();
        chk("lw.back_fetch", {29'd0, state}, 32'd0);

        // SW completing on the first MEM cycle
        fetch_decode(32'h0020A223);
        chk("sw.imm_sel", {29'd0, imm_sel}, 32'd1);
        chk("sw.store_sel", {29'd0, store_sel}, 32'd2);
        tick();
        chk("sw.exec_reg_write", {31'd0, reg_write}, 32'd0);
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("sw.mem_state", {29'd0, state}, 32'd3);
        chk("sw.mem_dm", {30'd0, dm_req, dm_write}, 32'd3);
        chk("sw.mem_pc_write", {31'd0, pc_write}, 32'd1);
        chk("sw.mem_reg_write", {31'd0, reg_write}, 32'd0);
        tick();
        dmem_ready = 1'b0;
        #1;
        chk("sw.back_fetch", {29'd0, state}, 32'd0);
        chk("sw.fetch_reg_write", {31'd0, reg_write}, 32'd0);

        // BEQ taken then not taken
        for (int t = 1; t >= 0; t--) begin
            fetch_decode(32'h00000463);
            chk($sformatf("beq%0d.imm_sel", t), {29'd0, imm_sel}, 32'd2);
            chk($sformatf("beq%0d.alu", t), {28'd0, alu_control}, 32'd1);
            chk($sformatf("beq%0d.br_sel", t), {29'd0, br_sel}, 32'd0);
            tick();
            br_taken = t[0];
            #1;
            chk($sformatf("beq%0d.exec_state", t), {29'd0, state}, 32'd2);
            chk($sformatf("beq%0d.exec_pc", t), {30'd0, pc_write, pc_src}, {30'd0, 1'b1, t[0]});
            tick();
            br_taken = 1'b0;
            chk($sformatf("beq%0d.back_fetch", t), {29'd0, state}, 32'd0);
        end

        // JAL: PC redirected in EXEC, link write without a second pc_write
        fetch_decode(32'h0000006F);
        chk("jal.imm_sel", {29'd0, imm_sel}, 32'd4);
        tick();
        chk("jal.exec_pc", {30'd0, pc_write, pc_src}, 32'd3);
        tick();
        chk("jal.wb", {29'd0, state}, 32'd4);
        chk("jal.wb_strobes", {30'd0, reg_write, pc_write}, 32'd2);
        tick();

        // Reset in the middle of a stalled store
        fetch_decode(32'h0020A223);
        tick();
        tick();
        chk("swrst.mem_dm", {30'd0, dm_req, dm_write}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("swrst.dm", {30'd0, dm_req, dm_write}, 32'd0);
        chk("swrst.pc_write", {31'd0, pc_write}, 32'd0);
        chk("swrst.state", {29'd0, state}, 32'd0);
        tick();
        chk("swrst.held_pc_write", {31'd0, pc_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("swrst.release_imem_req", {31'd0, imem_req}, 32'd1);

        // Illegal opcode locks up until reset
        fetch_decode(32'h00000000);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("ill%0d.state", i), {29'd0, state}, 32'd5);
            chk($sformatf("ill%0d.flags", i), {30'd0, illegal, imem_req}, 32'd2);
            chk($sformatf("ill%0d.enables", i), {27'd0, ir_write, pc_write, dm_req, dm_write, reg_write}, 32'd0);
        end
        #1;
        rst = 1'b1;
        #1;
        chk("illrst.state", {29'd0, state}, 32'd0);
        chk("illrst.illegal", {31'd0, illegal}, 32'd0);
        chk("illrst.imem_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("illrst.release_imem_req", {31'd0, imem_req}, 32'd1);
        fetch_decode(32'h002081B3);
        chk("illrst.recover_alu", {28'd0, alu_control}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
